// File: rtl/vx_ctrl_remap.sv
// vx_ctrl_remap: APB control/remap block sitting between a Vortex_axi core and
// the SoC AXI master port. Sequences the core through IDLE/RESET/RUN/DONE,
// gates its clock enable, remaps core addresses through NUM_WINDOWS base
// windows and raises a maskable completion interrupt.
// Optional feature macro: VX_REMAP_BOUNDS_CHECK_EN adds WIN_LIMIT registers
// and the addr_err interrupt source for out-of-window accesses.
module vx_ctrl_remap #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_WINDOWS    = 4,
  parameter int RESET_DELAY    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [31:0]               paddr,
  input  logic [31:0]               pwdata,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  input  logic [AXI_ADDR_WIDTH-1:0] core_araddr_raw,
  input  logic [AXI_ADDR_WIDTH-1:0] core_awaddr_raw,
  input  logic                      core_arvalid,
  input  logic                      core_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  input  logic                      core_busy,
  output logic                      core_reset,
  output logic                      core_clk_en,
  output logic                      irq
);

  localparam int W  = $clog2(NUM_WINDOWS);
  localparam int IW = (W > 0) ? W : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_MASK = {AXI_ADDR_WIDTH{1'b1}} >> W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                    state;
  logic [7:0]                cnt;
  logic                      busy_q;
  logic [1:0]                irq_status;
  logic [1:0]                irq_en;
  logic [1:0]                irq_clr;
  logic [7:0]                rst_cycles;
  logic [AXI_ADDR_WIDTH-1:0] win_base [NUM_WINDOWS];
`ifdef VX_REMAP_BOUNDS_CHECK_EN
  logic [AXI_ADDR_WIDTH-1:0] win_limit [NUM_WINDOWS];
  logic [AXI_ADDR_WIDTH-1:0] ar_lim, aw_lim;
`endif

  // APB decode
  logic [7:0] offs;
  logic [2:0] win_slot;
  logic       wr_en, rd_en, slot_ok;
  logic       sel_ctrl, sel_status, sel_irq_st, sel_irq_en, sel_rst_cyc;
  logic       sel_win_base, sel_win_lim;
  logic       cfg_wr, cfg_locked, start_wr, abort_wr, busy_fall;
  logic       done_set, addr_err_set;
  logic       unused_sig;

  assign offs         = paddr[7:0];
  assign win_slot     = offs[4:2];
  assign wr_en        = psel && penable && pwrite;
  assign rd_en        = psel && !pwrite;
  assign slot_ok      = ({1'b0, win_slot} < 4'(NUM_WINDOWS));
  assign sel_ctrl     = (offs == 8'h00);
  assign sel_status   = (offs == 8'h04);
  assign sel_irq_st   = (offs == 8'h08);
  assign sel_irq_en   = (offs == 8'h0C);
  assign sel_rst_cyc  = (offs == 8'h10);
  assign sel_win_base = (offs[7:5] == 3'b001) && (offs[1:0] == 2'b00) && slot_ok;
`ifdef VX_REMAP_BOUNDS_CHECK_EN
  assign sel_win_lim  = (offs[7:5] == 3'b010) && (offs[1:0] == 2'b00) && slot_ok;
  assign unused_sig   = ^paddr[31:8];
`else
  assign sel_win_lim  = 1'b0;
  assign unused_sig   = ^{paddr[31:8], core_arvalid, core_awvalid};
`endif

  assign cfg_locked = (state == ST_RESET) || (state == ST_RUN);
  assign cfg_wr     = wr_en && (sel_win_base || sel_win_lim || sel_rst_cyc);
  assign pslverr    = cfg_wr && cfg_locked;
  assign pready     = 1'b1;
  assign start_wr   = wr_en && sel_ctrl && pwdata[0];
  assign abort_wr   = wr_en && sel_ctrl && pwdata[1];
  assign busy_fall  = busy_q && !core_busy;
  assign done_set   = (state == ST_RUN) && busy_fall && !abort_wr;
  assign irq_clr    = (wr_en && sel_irq_st) ? pwdata[1:0] : 2'b00;

  // Window lookup for both address channels, plus optional bounds check
  logic [IW-1:0]             ar_idx, aw_idx;
  logic [AXI_ADDR_WIDTH-1:0] ar_off, aw_off, ar_base, aw_base;
  always_comb begin
    // Shifting by the full width yields idx=0 when there is a single window.
    ar_idx  = IW'(core_araddr_raw >> (AXI_ADDR_WIDTH - W));
    aw_idx  = IW'(core_awaddr_raw >> (AXI_ADDR_WIDTH - W));
    ar_off  = core_araddr_raw & OFF_MASK;
    aw_off  = core_awaddr_raw & OFF_MASK;
    ar_base = '0;
    aw_base = '0;
`ifdef VX_REMAP_BOUNDS_CHECK_EN
    ar_lim  = '0;
    aw_lim  = '0;
`endif
    for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
      if (ar_idx == IW'(i)) ar_base = win_base[i];
      if (aw_idx == IW'(i)) aw_base = win_base[i];
`ifdef VX_REMAP_BOUNDS_CHECK_EN
      if (ar_idx == IW'(i)) ar_lim = win_limit[i];
      if (aw_idx == IW'(i)) aw_lim = win_limit[i];
`endif
    end
`ifdef VX_REMAP_BOUNDS_CHECK_EN
    addr_err_set = (core_arvalid && (ar_off > ar_lim)) ||
                   (core_awvalid && (aw_off > aw_lim));
`else
    addr_err_set = 1'b0;
`endif
  end

  assign m_axi_araddr = ar_base + ar_off;
  assign m_axi_awaddr = aw_base + aw_off;

  // Core sequencing FSM with registered reset/clock-enable outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy_q      <= 1'b0;
      core_reset  <= 1'b1;
      core_clk_en <= 1'b0;
    end else begin
      busy_q <= core_busy;
      if (abort_wr) begin
        state       <= ST_IDLE;
        core_reset  <= 1'b1;
        core_clk_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start_wr) begin
              state       <= ST_RESET;
              cnt         <= (rst_cycles == 8'd0) ? 8'd1 : rst_cycles;
              core_reset  <= 1'b1;
              core_clk_en <= 1'b1;
            end
          end
          ST_RESET: begin
            if (cnt <= 8'd1) begin
              state       <= ST_RUN;
              core_reset  <= 1'b0;
              core_clk_en <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          ST_RUN: begin
            if (busy_fall) begin
              state       <= ST_DONE;
              core_reset  <= 1'b0;
              core_clk_en <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // Interrupt status (set beats W1C), enable and registered irq
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_status <= '0;
      irq_en     <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | {addr_err_set, done_set};
      if (wr_en && sel_irq_en) irq_en <= pwdata[1:0];
      irq <= |(irq_status & irq_en);
    end
  end

  // Configuration registers, frozen while the core is in RESET or RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cycles <= 8'(RESET_DELAY);
      for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
        win_base[i]  <= '0;
`ifdef VX_REMAP_BOUNDS_CHECK_EN
        win_limit[i] <= '1;
`endif
      end
    end else if (cfg_wr && !cfg_locked) begin
      if (sel_rst_cyc) rst_cycles <= pwdata[7:0];
      for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
        if (sel_win_base && (win_slot == 3'(i))) win_base[i] <= AXI_ADDR_WIDTH'(pwdata);
`ifdef VX_REMAP_BOUNDS_CHECK_EN
        if (sel_win_lim && (win_slot == 3'(i))) win_limit[i] <= AXI_ADDR_WIDTH'(pwdata);
`endif
      end
    end
  end

  // Combinational APB read mux
  always_comb begin
    prdata = '0;
    if (rd_en) begin
      if (sel_status)  prdata = {30'b0, state};
      if (sel_irq_st)  prdata = {30'b0, irq_status};
      if (sel_irq_en)  prdata = {30'b0, irq_en};
      if (sel_rst_cyc) prdata = {24'b0, rst_cycles};
      for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
        if (sel_win_base && (win_slot == 3'(i))) prdata = 32'(win_base[i]);
`ifdef VX_REMAP_BOUNDS_CHECK_EN
        if (sel_win_lim && (win_slot == 3'(i))) prdata = 32'(win_limit[i]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_vx_ctrl_remap.sv
// Self-checking bench for vx_ctrl_remap: randomized register, sequencing and
// remap stimulus compared against a behavioural model of the register file.
module tb_vx_ctrl_remap;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [31:0] core_araddr_raw, core_awaddr_raw, m_axi_araddr, m_axi_awaddr;
  logic        core_arvalid, core_awvalid, core_busy;
  logic        core_reset, core_clk_en, irq;

  always #5 clk = ~clk;

  vx_ctrl_remap #(
    .AXI_ADDR_WIDTH (32),
    .NUM_WINDOWS    (4),
    .RESET_DELAY    (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .prdata          (prdata),
    .pready          (pready),
    .pslverr         (pslverr),
    .core_araddr_raw (core_araddr_raw),
    .core_awaddr_raw (core_awaddr_raw),
    .core_arvalid    (core_arvalid),
    .core_awvalid    (core_awvalid),
    .m_axi_araddr    (m_axi_araddr),
    .m_axi_awaddr    (m_axi_awaddr),
    .core_busy       (core_busy),
    .core_reset      (core_reset),
    .core_clk_en     (core_clk_en),
    .irq             (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the window bases as seen by software
  logic [31:0] m_base [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Quarter of the address space per window: index by division, offset by modulo
  function automatic logic [31:0] ref_remap(input logic [31:0] raw);
    int unsigned idx;
    logic [31:0] off;
    idx = raw / 32'h4000_0000;
    off = raw % 32'h4000_0000;
    return m_base[idx] + off;
  endfunction

  task automatic apb_wr(input logic [7:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {24'h0, addr}; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_w(input logic [7:0] addr, input logic [31:0] data);
    logic e;
    apb_wr(addr, data, e);
  endtask

  task automatic apb_rd(input logic [7:0] addr, output logic [31:0] data);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {24'h0, addr};
    @(negedge clk);
    penable = 1'b1;
    #1 data = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(addr, d);
    check(tag, d, exp);
  endtask

  // Issue START and measure how many cycles the core sits in the RESET phase
  task automatic start_and_count(input string tag, input int n_exp);
    int n;
    apb_w(8'h00, 32'h1);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (core_reset && core_clk_en) begin
        n++;
        @(negedge clk);
      end else begin
        break;
      end
    end
    check(tag, n, n_exp);
    check({tag, "_run"}, {30'b0, core_reset, core_clk_en}, 32'h1);
  endtask

  // Raise then drop core_busy; the falling sample is cycle t
  task automatic busy_pulse();
    @(negedge clk);
    core_busy = 1'b1;
    @(negedge clk);
    core_busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic        e;
    logic [31:0] v, raw;
    int          n;

    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; core_araddr_raw = '0; core_awaddr_raw = '0;
    core_arvalid = 1'b0; core_awvalid = 1'b0; core_busy = 1'b0;
    for (int i = 0; i < 4; i++) m_base[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    check("rst_core_reset", {31'b0, core_reset}, 32'h1);
    check("rst_clk_en", {31'b0, core_clk_en}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_pslverr", {31'b0, pslverr}, 32'h0);
    check("rst_pready", {31'b0, pready}, 32'h1);
    check("rst_prdata_idle", prdata, 32'h0);
    rd_chk("rst_status", 8'h04, 32'h0);
    rd_chk("rst_rst_cycles", 8'h10, 32'h8);
    rd_chk("rst_irq_status", 8'h08, 32'h0);
    rd_chk("rst_irq_en", 8'h0C, 32'h0);
    rd_chk("rd_ctrl_wo", 8'h00, 32'h0);
    rd_chk("rd_unmapped", 8'h80, 32'h0);
    for (int i = 0; i < 4; i++) rd_chk("rst_win_base", 8'(8'h20 + 4 * i), 32'h0);
`ifdef VX_REMAP_BOUNDS_CHECK_EN
    rd_chk("rst_win_limit", 8'h40, 32'hFFFF_FFFF);
`else
    rd_chk("win_limit_absent", 8'h40, 32'h0);
    apb_w(8'h40, 32'h1234);
    rd_chk("win_limit_wr_ignored", 8'h40, 32'h0);
`endif

    // Random register readback with field masking
    for (int k = 0; k < 4; k++) begin
      v = $urandom;
      apb_w(8'h0C, v);
      rd_chk("irq_en_rb", 8'h0C, v & 32'h3);
      v = $urandom;
      apb_w(8'h10, v);
      rd_chk("rst_cycles_rb", 8'h10, v & 32'hFF);
    end
    apb_w(8'h0C, 32'h0);

    // Random RESET_CYCLES: RESET phase lasts max(n,1) cycles
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(0, 12);
      apb_w(8'h10, n);
      start_and_count("rand_reset_len", (n == 0) ? 1 : n);
      apb_w(8'h00, 32'h2);
      rd_chk("abort_status", 8'h04, 32'h0);
    end

    // Random window bases and addresses on both channels
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 4; i++) begin
        m_base[i] = $urandom;
        apb_w(8'(8'h20 + 4 * i), m_base[i]);
      end
      rd_chk("win_base_rb", 8'h2C, m_base[3]);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        core_araddr_raw = $urandom;
        core_awaddr_raw = $urandom;
        #1;
        check("remap_ar", m_axi_araddr, ref_remap(core_araddr_raw));
        check("remap_aw", m_axi_awaddr, ref_remap(core_awaddr_raw));
      end
    end

    // Directed remap cases, including modular wrap
    m_base[2] = 32'h8000_0000;
    apb_w(8'h28, m_base[2]);
    @(negedge clk);
    core_araddr_raw = 32'h8000_0010;
    #1 check("remap_win2", m_axi_araddr, 32'h8000_0010);
    m_base[1] = 32'hFFFF_FFF0;
    apb_w(8'h24, m_base[1]);
    @(negedge clk);
    core_araddr_raw = 32'h4000_0020;
    core_awaddr_raw = 32'h4000_0020;
    #1 check("remap_wrap_ar", m_axi_araddr, 32'h0000_0010);
    check("remap_wrap_aw", m_axi_awaddr, ref_remap(32'h4000_0020));

    // Base write takes effect the cycle after it commits
    core_araddr_raw = 32'h0000_0100;
    m_base[0] = 32'h0001_0000;
    apb_w(8'h20, m_base[0]);
    #1 check("base_wr_next_cycle", m_axi_araddr, 32'h0001_0100);

    // Completion interrupt flow
    apb_w(8'h08, 32'h3);
    apb_w(8'h0C, 32'h1);
    apb_w(8'h10, 32'h3);
    start_and_count("reset_len_3", 3);
    rd_chk("status_run", 8'h04, 32'h2);
    busy_pulse();
    check("done_outputs", {30'b0, core_reset, core_clk_en}, 32'h0);
    check("irq_not_yet", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_raised", {31'b0, irq}, 32'h1);
    rd_chk("status_done", 8'h04, 32'h3);
    rd_chk("irq_status_done", 8'h08, 32'h1);
    apb_w(8'h08, 32'h1);
    @(negedge clk);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // RESET_CYCLES=0 gives a single cycle, START accepted from DONE
    apb_w(8'h10, 32'h0);
    start_and_count("reset_len_0", 1);

    // Configuration writes are refused while running
    apb_wr(8'h20, 32'hDEAD_BEEF, e);
    check("pslverr_win", {31'b0, e}, 32'h1);
    rd_chk("win_unchanged", 8'h20, m_base[0]);
    apb_wr(8'h10, 32'h55, e);
    check("pslverr_rstcyc", {31'b0, e}, 32'h1);
    rd_chk("rstcyc_unchanged", 8'h10, 32'h0);
    apb_wr(8'h0C, 32'h1, e);
    check("no_pslverr_irq_en", {31'b0, e}, 32'h0);

    // START ignored in RUN; START+ABORT returns to IDLE
    apb_w(8'h00, 32'h1);
    rd_chk("start_in_run_ignored", 8'h04, 32'h2);
    apb_w(8'h00, 32'h3);
    rd_chk("abort_wins", 8'h04, 32'h0);
    check("idle_outputs", {30'b0, core_reset, core_clk_en}, 32'h2);

    // RUN -> DONE -> START -> RESET again
    apb_w(8'h10, 32'h2);
    start_and_count("reset_len_2", 2);
    busy_pulse();
    rd_chk("status_done2", 8'h04, 32'h3);
    start_and_count("restart_from_done", 2);
    apb_w(8'h00, 32'h2);

    // Bounds checking
    apb_w(8'h08, 32'h3);
`ifdef VX_REMAP_BOUNDS_CHECK_EN
    apb_w(8'h40, 32'hFF);
    rd_chk("win_limit_rb", 8'h40, 32'hFF);
`endif
    @(negedge clk);
    core_araddr_raw = 32'h0000_0080;
    core_arvalid = 1'b1;
    @(negedge clk);
    core_arvalid = 1'b0;
    rd_chk("in_bounds_no_err", 8'h08, 32'h0);
    @(negedge clk);
    raw = 32'h0000_0100;
    core_araddr_raw = raw;
    core_arvalid = 1'b1;
    #1 check("oob_forwarded", m_axi_araddr, ref_remap(raw));
    @(negedge clk);
    core_arvalid = 1'b0;
`ifdef VX_REMAP_BOUNDS_CHECK_EN
    rd_chk("addr_err_set", 8'h08, 32'h2);
`else
    rd_chk("addr_err_absent", 8'h08, 32'h0);
`endif

    // Reset asserted mid-RUN
    apb_w(8'h08, 32'h3);
    apb_w(8'h10, 32'h1);
    start_and_count("reset_len_1", 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_core_reset", {31'b0, core_reset}, 32'h1);
    check("midrun_clk_en", {31'b0, core_clk_en}, 32'h0);
    check("midrun_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_base[i] = '0;
    rd_chk("midrun_status", 8'h04, 32'h0);
    rd_chk("midrun_rst_cycles", 8'h10, 32'h8);
    rd_chk("midrun_win_base", 8'h24, m_base[1]);
    rd_chk("midrun_irq_en", 8'h0C, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
